// File: rtl/imem_pkg.sv
// imem_pkg: shared encodings and defaults for the instruction-memory responder.
//   state_t  : responder FSM states (IDLE, WAIT, RESP)
//   CNT_W    : width of the access-latency counter
//   DEF_LAT  : default access latency in cycles
//   DEF_AW   : default word-index width
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam int CNT_W   = 4;
   localparam int DEF_LAT = 4;
   localparam int DEF_AW  = 15;

endpackage

// File: rtl/imem_array.sv
// imem_array: 2^AW x 16 instruction storage, one sync write port and one registered read port.
//   clk, rst    : clock, async active-high reset (clears only the read register)
//   wr_en_i     : write enable; wr_idx_i / wr_data_i give word index and data
//   rd_en_i     : capture mem[rd_idx_i] into rd_data_o on this edge
//   rd_data_o   : last captured word, held between reads
module imem_array
   import imem_pkg::*;
#(
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_idx_i,
   input  logic [15:0]   wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_idx_i,
   output logic [15:0]   rd_data_o
);

   logic [15:0] mem_q [2**AW];
   logic [15:0] rd_data_q;

   // Storage is never reset so a preloaded image survives a reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
   end

   // Both blocks sample mem_q before the write lands, so a same-edge
   // write to the read word returns the old contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: multi-cycle instruction-memory responder for the fetch stage.
//   clk, rst   : clock, async active-high reset
//   req_valid  : fetch request present; req_addr is its byte address
//   flush      : branch redirect, cancels any outstanding or presented request
//   ld_en      : load-port write; ld_addr byte address, ld_data word
//   rsp_valid  : one-cycle pulse with rsp_data (both registered)
//   busy       : combinational stall to the fetch stage
module imem_responder
   import imem_pkg::*;
#(
   parameter int LAT = DEF_LAT,
   parameter int AW  = DEF_AW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [15:0] req_addr,
   input  logic        flush,
   input  logic        ld_en,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        busy
);

   if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $error("imem_responder: LAT must be in 1..15");
   end
   if (AW < 1 || AW > 15) begin : g_bad_aw
      $error("imem_responder: AW must be in 1..15");
   end

   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LAT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rd_en;
   logic             unused_addr_bits;

   // Byte bit 0 and anything above the word index are ignored by design.
   assign unused_addr_bits = ^{req_addr, ld_addr};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rsp_valid_d = 1'b0;
      rd_en       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && !flush) begin
               state_d = ST_WAIT;
               cnt_d   = LAT_INIT;
               addr_d  = req_addr[AW:1];
            end
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               rd_en       = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   imem_array #(.AW(AW)) u_array (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (ld_en),
      .wr_idx_i  (ld_addr[AW:1]),
      .wr_data_i (ld_data),
      .rd_en_i   (rd_en),
      .rd_idx_i  (addr_q),
      .rd_data_o (rsp_data)
   );

   assign rsp_valid = rsp_valid_q;
   // The PC stays frozen until the response cycle itself.
   assign busy      = req_valid & ~rsp_valid_q & ~flush;

endmodule
